dcache_dm: RTL and testbench
============================

DCACHE_DM -- requirements
Module: dcache_dm

Interface
REQ-001 Parameter NUM_LINES, default 64, is the number of cache lines and SHALL be a power of 2, minimum 2.
REQ-002 Parameter LINE_BYTES, default 16, is the bytes per line and SHALL be a power of 2, minimum 4.
REQ-003 Parameter ADDR_W, default 32, is the byte-address width.
REQ-004 clk  in  1  sole clock; all state changes on posedge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 dmem_addr  in  ADDR_W  byte address of the CPU access.
REQ-007 dmem_wdata  in  32  store data, right-aligned.
REQ-008 dmem_read / dmem_write  in  1 each  access request; both high is treated as a write.
REQ-009 dmem_rdu / dmem_hwrd / dmem_wrd  in  1 each  unsigned-read select, halfword size, word size; neither size bit set means byte.
REQ-010 flush  in  1  invalidate all lines.
REQ-011 dmem_drdy  out  1  access complete this cycle.
REQ-012 dmem_rdata  out  32  load data, sign- or zero-extended.
REQ-013 dmem_err  out  1  misaligned access; valid only while dmem_drdy is high.
REQ-014 mem_req  out  1  backing-memory request.
REQ-015 mem_we  out  1  write request.
REQ-016 mem_addr  out  ADDR_W  word-aligned address.
REQ-017 mem_wdata  out  32  write data.
REQ-018 mem_wstrb  out  4  byte-lane enables.
REQ-019 mem_ack  in  1  request accepted and completed this cycle; mem_rdata is valid on read ack.
REQ-020 mem_rdata  in  32  read data.

Function
REQ-021 Organisation: direct-mapped, write-through, no-write-allocate.
- offset = addr[log2(LINE_BYTES)-1:0]
- index = next log2(NUM_LINES) bits
- tag = remaining bits
- per line: valid bit, tag, LINE_BYTES data bytes.
REQ-022 The CPU SHALL hold all request inputs stable until the cycle dmem_drdy is high; a request is consumed in that cycle.
REQ-023 FSM states: IDLE, REFILL, WRITE.
REQ-024 In IDLE, a read hit SHALL assert dmem_drdy combinationally in the same cycle, with zero wait states.
REQ-025 Read data extension:
- byte: zero-extended when dmem_rdu=1, else sign-extended from bit 7
- halfword: extended from bit 15 under the same rule
- word: unmodified.
REQ-026 A read miss in IDLE SHALL transition to REFILL, which fetches LINE_BYTES/4 words in ascending address order from the line base.
- mem_req=1 and mem_we=0 for each word; the word counter advances on mem_ack.
REQ-027 On the ack of the last refill word, the FSM SHALL write the tag and set valid, then return to IDLE; the read then hits there, so dmem_drdy rises the cycle after the last ack.
REQ-028 A write in IDLE SHALL transition to WRITE.
- mem_req=1, mem_we=1, mem_addr={addr[ADDR_W-1:2],2'b00}
- mem_wdata = wdata shifted to lane addr[1:0]
- mem_wstrb = 0001, 0011 or 1111 shifted by addr[1:0].
REQ-029 On mem_ack in WRITE, the block SHALL update the strobed bytes if the line hits, assert dmem_drdy that cycle, and return to IDLE; a write miss SHALL leave the cache unchanged.
REQ-030 mem_req, mem_addr, mem_we, mem_wdata and mem_wstrb SHALL remain stable from assertion until mem_ack.
REQ-031 Misaligned access (halfword with addr[0]=1, or word with addr[1:0]!=0) SHALL assert dmem_drdy and dmem_err in the same IDLE cycle, with no memory or cache effect and dmem_rdata=0.
REQ-032 A flush SHALL clear all valid bits at the next posedge when sampled in IDLE with no request; otherwise it SHALL be held pending and applied on the first return to IDLE, before any new lookup.
REQ-033 dmem_drdy SHALL be low whenever no request is present, and high for exactly one cycle per request.

Reset
REQ-034 While rst_n=0:
- state=IDLE
- all valid bits=0
- refill counter=0
- mem_req=0, mem_we=0, mem_wstrb=0
- dmem_drdy=0, dmem_err=0, dmem_rdata=0.
REQ-035 Reset asserted mid-REFILL or mid-WRITE SHALL abandon the transaction; the partial line stays invalid. Data-array contents need not be reset.

Verification
REQ-036 Cold read: word load at 0x100, memory returns 0x11,0x22,0x33,0x44 for words 0x100..0x10C, ack delay 2 -> 4 read requests, dmem_rdata=0x00000011 one cycle after the last ack; a reload of 0x104 gives drdy in the same cycle, 0x22.
REQ-037 Sign extension: line holds 0x000080F0 at 0x200 -> lb 0x200 gives 0xFFFFFFF0, lbu gives 0x000000F0, lh 0x200 gives 0xFFFF80F0, lhu gives 0x000080F0.
REQ-038 Write hit: sh 0xBEEF to 0x102 on a cached line -> mem_wstrb=1100, mem_wdata=0xBEEF0000; a later lw 0x100 hits, 0xBEEF0011.
REQ-039 Write miss then read: sw 0xCAFEBABE to 0x400 (not cached) -> one memory write, no refill; lw 0x400 then misses and refills.
REQ-040 Misalign and flush: lw 0x102 -> drdy=1, err=1, mem_req stays 0; flush then lw 0x100 -> miss and refill.
REQ-041 Reset on the 2nd refill word -> mem_req=0 immediately; after release, lw 0x100 misses again.

Source files
------------

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache between a CPU load/store
// port and a single-word backing memory.
`timescale 1ns/1ps
module dcache_dm #(
   parameter int unsigned NUM_LINES  = 64,
   parameter int unsigned LINE_BYTES = 16,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] dmem_addr,
   input  logic [31:0]       dmem_wdata,
   input  logic              dmem_read,
   input  logic              dmem_write,
   input  logic              dmem_rdu,
   input  logic              dmem_hwrd,
   input  logic              dmem_wrd,
   input  logic              flush,
   output logic              dmem_drdy,
   output logic [31:0]       dmem_rdata,
   output logic              dmem_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
   localparam int unsigned IDX_W  = $clog2(NUM_LINES);
   localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;
   localparam int unsigned DW     = OFF_W + IDX_W - 2;
   localparam int unsigned CNT_W  = OFF_W - 1;
   localparam int unsigned NWORDS = NUM_LINES * LINE_BYTES / 4;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_BYTES / 4 - 1);

   typedef enum logic [1:0] {StIdle, StRefill, StWrite} state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic                 flush_pend_q, flush_pend_d;
   logic [TAG_W-1:0]     tag_q [NUM_LINES];
   logic [31:0]          data_q [NWORDS];

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [DW-1:0]     widx;
   logic [ADDR_W-1:0] refill_addr;
   logic [4:0]        lane_sh;
   logic [31:0]       rword, wdata_sh, load_data;
   logic [3:0]        strb_base, strb;
   logic              req, misalign, hit, last_word;
   logic              drdy_c, err_c;
   logic [31:0]       rdata_c;

   assign idx       = dmem_addr[OFF_W+IDX_W-1:OFF_W];
   assign tag       = dmem_addr[ADDR_W-1:OFF_W+IDX_W];
   // Flat word index into the data array: {line index, word within line}.
   assign widx      = dmem_addr[OFF_W+IDX_W-1:2];
   assign req       = dmem_read | dmem_write;
   assign misalign  = dmem_wrd ? (dmem_addr[1:0] != 2'b00) : (dmem_hwrd & dmem_addr[0]);
   assign hit       = valid_q[idx] && (tag_q[idx] == tag);
   assign last_word = (cnt_q == LAST_CNT);
   assign refill_addr = {dmem_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} + ADDR_W'({cnt_q, 2'b00});
   assign lane_sh   = {dmem_addr[1:0], 3'b000};
   assign rword     = data_q[widx] >> lane_sh;
   assign wdata_sh  = dmem_wdata << lane_sh;
   assign strb      = strb_base << dmem_addr[1:0];

   always_comb begin
      strb_base = 4'b0001;
      load_data = {{24{~dmem_rdu & rword[7]}}, rword[7:0]};
      if (dmem_wrd) begin
         strb_base = 4'b1111;
         load_data = rword;
      end else if (dmem_hwrd) begin
         strb_base = 4'b0011;
         load_data = {{16{~dmem_rdu & rword[15]}}, rword[15:0]};
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      valid_d      = valid_q;
      flush_pend_d = flush_pend_q | flush;
      drdy_c       = 1'b0;
      err_c        = 1'b0;
      rdata_c      = 32'h0;
      case (state_q)
         StIdle: begin
            if (flush_pend_q) begin
               // Deferred flush takes this cycle; any waiting request is looked up next cycle.
               valid_d      = '0;
               flush_pend_d = 1'b0;
            end else if (req) begin
               if (misalign) begin
                  drdy_c = 1'b1;
                  err_c  = 1'b1;
               end else if (dmem_write) begin
                  state_d = StWrite;
               end else if (hit) begin
                  drdy_c  = 1'b1;
                  rdata_c = load_data;
               end else begin
                  // Invalidate the victim first so an aborted refill never leaves stale data valid.
                  state_d      = StRefill;
                  cnt_d        = '0;
                  valid_d[idx] = 1'b0;
               end
            end else if (flush) begin
               valid_d      = '0;
               flush_pend_d = 1'b0;
            end
         end
         StRefill: begin
            if (mem_ack) begin
               cnt_d = cnt_q + 1'b1;
               if (last_word) begin
                  cnt_d        = '0;
                  valid_d[idx] = 1'b1;
                  state_d      = StIdle;
               end
            end
         end
         StWrite: begin
            if (mem_ack) begin
               drdy_c  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         valid_q      <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         valid_q      <= valid_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == StRefill && mem_ack) begin
         data_q[refill_addr[OFF_W+IDX_W-1:2]] <= mem_rdata;
         if (last_word) tag_q[idx] <= tag;
      end else if (state_q == StWrite && mem_ack && hit) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) data_q[widx][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
   end

   assign dmem_drdy  = rst_n & drdy_c;
   assign dmem_err   = rst_n & err_c;
   assign dmem_rdata = rst_n ? rdata_c : 32'h0;
   assign mem_req    = (state_q != StIdle);
   assign mem_we     = (state_q == StWrite);
   assign mem_addr   = (state_q == StRefill) ? refill_addr : {dmem_addr[ADDR_W-1:2], 2'b00};
   assign mem_wdata  = mem_we ? wdata_sh : 32'h0;
   assign mem_wstrb  = mem_we ? strb : 4'b0000;

endmodule

// File: tb/tb_dcache_dm.sv
// Self-checking bench for dcache_dm: table of CPU accesses scored against a backing-memory
// model, plus hand sequences for flush and reset corner cases.
`timescale 1ns/1ps
module tb_dcache_dm;

   localparam int KH = 0;  // zero-wait hit or misalign
   localparam int KR = 1;  // miss with 4-word refill
   localparam int KW = 2;  // write-through
   localparam int KX = 3;  // data only

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rd, wr, rdu, hw, wd;
      int          kind;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic [3:0]  exp_strb;
      logic [31:0] exp_mdata;
   } vec_t;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [31:0] dmem_addr = '0, dmem_wdata = '0;
   logic        dmem_read = 0, dmem_write = 0, dmem_rdu = 0, dmem_hwrd = 0, dmem_wrd = 0;
   logic        flush = 0;
   logic        dmem_drdy, dmem_err, mem_req, mem_we;
   logic [31:0] dmem_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   dcache_dm dut (
      .clk(clk), .rst_n(rst_n), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_rdu(dmem_rdu),
      .dmem_hwrd(dmem_hwrd), .dmem_wrd(dmem_wrd), .flush(flush), .dmem_drdy(dmem_drdy),
      .dmem_rdata(dmem_rdata), .dmem_err(dmem_err), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Backing memory: ack after ACK_DLY cycles of a held request.
   localparam int ACK_DLY = 2;
   logic [31:0] mem [logic [31:0]];
   int          wcnt = 0, rd_acks = 0, wr_acks = 0, last_ack_cyc = 0;
   logic [31:0] last_waddr = '0, last_wdata = '0;
   logic [3:0]  last_wstrb = '0;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'h5A5A_0000;
   endfunction

   always @(posedge clk) begin
      logic [31:0] cur;
      #1;
      mem_ack = 1'b0;
      if (rst_n && mem_req) begin
         wcnt++;
         if (wcnt >= ACK_DLY) begin
            wcnt = 0;
            mem_ack = 1'b1;
            last_ack_cyc = cyc;
            if (mem_we) begin
               cur = mem_rd(mem_addr);
               for (int b = 0; b < 4; b++)
                  if (mem_wstrb[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
               mem[mem_addr] = cur;
               last_waddr = mem_addr;
               last_wdata = mem_wdata;
               last_wstrb = mem_wstrb;
               wr_acks++;
            end else begin
               mem_rdata = mem_rd(mem_addr);
               rd_acks++;
            end
         end
      end else begin
         wcnt = 0;
      end
   end

   // Request outputs must hold from assertion until ack.
   logic [69:0] prev_snap;
   bit          pend_prev = 0;
   always @(negedge clk) begin
      #1;
      if (!rst_n) begin
         pend_prev = 0;
      end else begin
         if (pend_prev)
            chk("mem_stable", 32'(prev_snap == {mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb}),
                32'd1);
         pend_prev = mem_req && !mem_ack;
         prev_snap = {mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb};
      end
   end

   vec_t sb_q[$];
   vec_t tbl[$];

   function automatic vec_t ld(input logic [31:0] a, input int sz, input bit u, input int k,
                               input logic [31:0] d, input bit e);
      vec_t v;
      v.addr = a; v.wdata = '0; v.rd = 1'b1; v.wr = 1'b0; v.rdu = u;
      v.hw = (sz == 1); v.wd = (sz == 2); v.kind = k; v.exp_rdata = d; v.exp_err = e;
      v.exp_strb = '0; v.exp_mdata = '0;
      return v;
   endfunction

   function automatic vec_t st(input logic [31:0] a, input logic [31:0] d, input int sz,
                               input logic [3:0] s, input logic [31:0] md, input bit both);
      vec_t v;
      v.addr = a; v.wdata = d; v.rd = both; v.wr = 1'b1; v.rdu = 1'b0;
      v.hw = (sz == 1); v.wd = (sz == 2); v.kind = KW; v.exp_rdata = '0; v.exp_err = 1'b0;
      v.exp_strb = s; v.exp_mdata = md;
      return v;
   endfunction

   task automatic clear_req();
      dmem_read = 0; dmem_write = 0; dmem_rdu = 0; dmem_hwrd = 0; dmem_wrd = 0;
      dmem_addr = '0; dmem_wdata = '0;
   endtask

   task automatic run_vec(input vec_t v, input string name);
      int   r0, w0, waited;
      vec_t e;
      @(negedge clk);
      r0 = rd_acks; w0 = wr_acks;
      dmem_addr = v.addr; dmem_wdata = v.wdata; dmem_read = v.rd; dmem_write = v.wr;
      dmem_rdu = v.rdu; dmem_hwrd = v.hw; dmem_wrd = v.wd;
      sb_q.push_back(v);
      #1;
      waited = 0;
      while (!dmem_drdy && waited < 100) begin
         @(negedge clk); #1; waited++;
      end
      e = sb_q.pop_front();
      if (!dmem_drdy) begin
         checks++; errors++;
         $display("FAIL %s drdy_timeout: got 0 expected 1", name);
      end else begin
         if (e.kind != KW) chk({name, " rdata"}, dmem_rdata, e.exp_rdata);
         chk({name, " err"}, 32'(dmem_err), 32'(e.exp_err));
         case (e.kind)
            KH: begin
               chk({name, " wait"}, 32'(waited), 32'd0);
               chk({name, " mem_traffic"}, 32'(rd_acks - r0 + wr_acks - w0), 32'd0);
            end
            KR: begin
               chk({name, " reads"}, 32'(rd_acks - r0), 32'd4);
               chk({name, " writes"}, 32'(wr_acks - w0), 32'd0);
               chk({name, " drdy_cyc"}, 32'(cyc), 32'(last_ack_cyc + 1));
            end
            KW: begin
               chk({name, " reads"}, 32'(rd_acks - r0), 32'd0);
               chk({name, " writes"}, 32'(wr_acks - w0), 32'd1);
               chk({name, " drdy_cyc"}, 32'(cyc), 32'(last_ack_cyc));
               chk({name, " wstrb"}, 32'(last_wstrb), 32'(e.exp_strb));
               chk({name, " wdata"}, last_wdata, e.exp_mdata);
               chk({name, " waddr"}, last_waddr, e.addr & 32'hFFFF_FFFC);
            end
            default: ;
         endcase
      end
      @(negedge clk);
      clear_req();
      #1;
      chk({name, " drdy_idle"}, 32'(dmem_drdy), 32'd0);
   endtask

   task automatic flush_pulse();
      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int r0, waited;
      mem[32'h100] = 32'h11; mem[32'h104] = 32'h22; mem[32'h108] = 32'h33;
      mem[32'h10C] = 32'h44; mem[32'h200] = 32'h0000_80F0;

      // Reset with a misaligned request present: all outputs must stay quiet.
      dmem_read = 1; dmem_wrd = 1; dmem_addr = 32'h102;
      repeat (3) @(negedge clk);
      #1;
      chk("rst drdy", 32'(dmem_drdy), 0);
      chk("rst err", 32'(dmem_err), 0);
      chk("rst rdata", dmem_rdata, 0);
      chk("rst mem_req", 32'(mem_req), 0);
      chk("rst mem_we", 32'(mem_we), 0);
      chk("rst mem_wstrb", 32'(mem_wstrb), 0);
      clear_req();
      @(negedge clk) rst_n = 1'b1;

      tbl.push_back(ld(32'h100, 2, 0, KR, 32'h0000_0011, 0));
      tbl.push_back(ld(32'h104, 2, 0, KH, 32'h0000_0022, 0));
      tbl.push_back(ld(32'h10C, 2, 0, KH, 32'h0000_0044, 0));
      tbl.push_back(ld(32'h200, 0, 0, KR, 32'hFFFF_FFF0, 0));
      tbl.push_back(ld(32'h200, 0, 1, KH, 32'h0000_00F0, 0));
      tbl.push_back(ld(32'h200, 1, 0, KH, 32'hFFFF_80F0, 0));
      tbl.push_back(ld(32'h200, 1, 1, KH, 32'h0000_80F0, 0));
      tbl.push_back(ld(32'h201, 0, 0, KH, 32'hFFFF_FF80, 0));
      tbl.push_back(ld(32'h202, 1, 0, KH, 32'h0000_0000, 0));
      tbl.push_back(st(32'h102, 32'h0000_BEEF, 1, 4'b1100, 32'hBEEF_0000, 0));
      tbl.push_back(ld(32'h100, 2, 0, KH, 32'hBEEF_0011, 0));
      tbl.push_back(st(32'h400, 32'hCAFE_BABE, 2, 4'b1111, 32'hCAFE_BABE, 0));
      tbl.push_back(ld(32'h400, 2, 0, KR, 32'hCAFE_BABE, 0));
      tbl.push_back(ld(32'h102, 2, 0, KH, 32'h0000_0000, 1));
      tbl.push_back(ld(32'h201, 1, 0, KH, 32'h0000_0000, 1));
      tbl.push_back(st(32'h203, 32'h0000_005A, 0, 4'b1000, 32'h5A00_0000, 0));
      tbl.push_back(ld(32'h200, 2, 0, KH, 32'h5A00_80F0, 0));
      tbl.push_back(st(32'h600, 32'h0000_0077, 0, 4'b0001, 32'h0000_0077, 0));
      tbl.push_back(ld(32'h200, 2, 0, KH, 32'h5A00_80F0, 0));
      tbl.push_back(ld(32'h500, 2, 0, KR, 32'h5A5A_0500, 0));
      tbl.push_back(ld(32'h100, 2, 0, KR, 32'hBEEF_0011, 0));
      tbl.push_back(st(32'h106, 32'h0000_1234, 1, 4'b1100, 32'h1234_0000, 1));
      tbl.push_back(ld(32'h104, 2, 0, KH, 32'h1234_0022, 0));
      tbl.push_back(ld(32'h106, 1, 1, KH, 32'h0000_1234, 0));

      foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

      // Idle flush invalidates everything.
      flush_pulse();
      #1;
      chk("flush drdy_idle", 32'(dmem_drdy), 0);
      run_vec(ld(32'h104, 2, 0, KR, 32'h1234_0022, 0), "flush_reload");
      run_vec(ld(32'h100, 2, 0, KH, 32'hBEEF_0011, 0), "flush_rehit");

      // Flush arriving mid-refill is deferred, yet still invalidates the old contents.
      fork
         run_vec(ld(32'h300, 2, 0, KX, 32'h5A5A_0300, 0), "flush_in_refill");
         begin
            repeat (3) @(negedge clk);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
         end
      join
      run_vec(ld(32'h104, 2, 0, KR, 32'h1234_0022, 0), "pending_flush_miss");

      // Reset during the second refill word abandons the line.
      flush_pulse();
      @(negedge clk);
      dmem_read = 1; dmem_wrd = 1; dmem_addr = 32'h100;
      r0 = rd_acks;
      waited = 0;
      while (rd_acks == r0 && waited < 50) begin
         @(negedge clk); waited++;
      end
      chk("rst_mid first_ack", 32'(rd_acks - r0), 32'd1);
      @(negedge clk);
      chk("rst_mid req_before", 32'(mem_req), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid mem_req", 32'(mem_req), 0);
      chk("rst_mid mem_we", 32'(mem_we), 0);
      chk("rst_mid drdy", 32'(dmem_drdy), 0);
      chk("rst_mid rdata", dmem_rdata, 0);
      clear_req();
      @(negedge clk) rst_n = 1'b1;
      run_vec(ld(32'h100, 2, 0, KR, 32'hBEEF_0011, 0), "after_reset_miss");

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
